// File: rtl/johnson_4_pkg.sv
// Shared constants for the 4-stage Johnson counter: stage/state counts and the
// legal pattern table in index order, used by both the decoder and its bench.
package johnson_4_pkg;

    localparam int JOHNSON_STAGES = 4;
    localparam int JOHNSON_STATES = 8;

    localparam logic [3:0] JOHNSON_SEQ [JOHNSON_STATES] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0111,
        4'b1111, 4'b1110, 4'b1100, 4'b1000
    };

    function automatic logic [3:0] johnson_advance(input logic [3:0] state);
        return {state[2:0], ~state[3]};
    endfunction

endpackage

// File: rtl/johnson_dff.sv
// Single ring stage: D flip-flop with asynchronous active-high reset to 0.
module johnson_dff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // Stage storage; q is the bit a bench may force to preload a pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/johnson_4.sv
// 4-stage twisted-ring counter with complement, index and one-hot decode,
// plus illegal-pattern detection that forces the ring back to 0000.
module johnson_4
    import johnson_4_pkg::*;
#(
    parameter int WIDTH = JOHNSON_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [2:0]       state_idx,
    output logic [7:0]       state_dec,
    output logic             illegal
);

    logic [3:0] stage_q;
    logic [3:0] stage_d;
    logic [2:0] idx_s;
    logic [7:0] dec_s;
    logic       illegal_s;

    // Table lookup: a pattern is legal only if it matches one table entry.
    always_comb begin
        idx_s     = 3'd0;
        dec_s     = 8'b0000_0000;
        illegal_s = 1'b1;
        for (int i = 0; i < JOHNSON_STATES; i++) begin
            if (stage_q == JOHNSON_SEQ[i]) begin
                idx_s     = i[2:0];
                dec_s[i]  = 1'b1;
                illegal_s = 1'b0;
            end else begin
                dec_s[i]  = dec_s[i];
            end
        end
    end

    // Recovery from an illegal pattern takes priority over the enable.
    always_comb begin
        stage_d = stage_q;
        if (illegal_s) begin
            stage_d = 4'b0000;
        end else if (en) begin
            stage_d = johnson_advance(stage_q);
        end else begin
            stage_d = stage_q;
        end
    end

    johnson_dff d0 (.clk(clk), .rst(rst), .d(stage_d[0]), .q(stage_q[0]));
    johnson_dff d1 (.clk(clk), .rst(rst), .d(stage_d[1]), .q(stage_q[1]));
    johnson_dff d2 (.clk(clk), .rst(rst), .d(stage_d[2]), .q(stage_q[2]));
    johnson_dff d3 (.clk(clk), .rst(rst), .d(stage_d[3]), .q(stage_q[3]));

    assign q         = stage_q;
    assign qbar      = ~stage_q;
    assign state_idx = idx_s;
    assign state_dec = dec_s;
    assign illegal   = illegal_s;

endmodule

// File: tb/tb_johnson_4.sv
// Bench for johnson_4: directed reset/hold/recovery/preload checks, then a
// randomized phase scored against an index-based reference model.
module tb_johnson_4;
    import johnson_4_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] q;
    logic [3:0] qbar;
    logic [2:0] state_idx;
    logic [7:0] state_dec;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] q;
        int         idx;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    johnson_4 #(.WIDTH(4)) uut (
        .clk(clk), .rst(rst), .en(en), .q(q), .qbar(qbar),
        .state_idx(state_idx), .state_dec(state_dec), .illegal(illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [3:0] eq, input logic [2:0] eidx,
                             input logic [7:0] edec, input logic eill);
        chk({name, ".q"}, {28'd0, q}, {28'd0, eq});
        chk({name, ".qbar"}, {28'd0, qbar}, {28'd0, ~eq});
        chk({name, ".idx"}, {29'd0, state_idx}, {29'd0, eidx});
        chk({name, ".dec"}, {24'd0, state_dec}, {24'd0, edec});
        chk({name, ".illegal"}, {31'd0, illegal}, {31'd0, eill});
    endtask

    task automatic check_legal(input string name, input int idx);
        logic [7:0] dec;
        dec      = 8'h00;
        dec[idx] = 1'b1;
        check_out(name, JOHNSON_SEQ[idx], idx[2:0], dec, 1'b0);
    endtask

    function automatic int legal_index(input logic [3:0] p);
        for (int i = 0; i < JOHNSON_STATES; i++) begin
            if (JOHNSON_SEQ[i] == p) return i;
        end
        return -1;
    endfunction

    task automatic force_pattern(input logic [3:0] p);
        force uut.d0.q = p[0];
        force uut.d1.q = p[1];
        force uut.d2.q = p[2];
        force uut.d3.q = p[3];
        #1;
        release uut.d0.q;
        release uut.d1.q;
        release uut.d2.q;
        release uut.d3.q;
    endtask

    // Monitor: one expected state per clock edge while the scoreboard is fed.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb.pattern", {28'd0, q}, {28'd0, e.q});
                check_legal("sb", e.idx);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int         mi;
        logic [3:0] p;
        rst = 1'b1;
        en  = 1'b0;
        #6;
        check_out("reset", 4'b0000, 3'd0, 8'b0000_0001, 1'b0);
        #6;
        rst = 1'b0;
        en  = 1'b1;

        // Count through 27 edges so the ring ends on 0111 (index 3).
        for (int k = 1; k <= 27; k++) begin
            @(posedge clk);
            #1;
            check_legal("count", k % JOHNSON_STATES);
        end

        en = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_out("hold", 4'b0111, 3'd3, 8'b0000_1000, 1'b0);
        end
        en = 1'b1;
        @(posedge clk);
        #1;
        check_legal("reenable", 4);
        @(posedge clk);
        #1;
        check_legal("pre_rst", 5);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 4'b0000, 3'd0, 8'b0000_0001, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_legal("post_rst", 1);

        @(negedge clk);
        en = 1'b0;
        force_pattern(4'b0101);
        check_out("illegal", 4'b0101, 3'd0, 8'b0000_0000, 1'b1);
        @(posedge clk);
        #1;
        check_legal("recover", 0);
        @(posedge clk);
        #1;
        check_legal("recover_hold", 0);

        en = 1'b1;
        @(posedge clk);
        #1;
        check_legal("adv1", 1);
        @(posedge clk);
        #1;
        check_legal("adv2", 2);
        @(negedge clk);
        force_pattern(4'b0000);
        check_legal("preload", 0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            check_legal("preload_seq", k % JOHNSON_STATES);
        end

        // Randomized phase: model tracks the position in the legal cycle.
        mi = 0;
        for (int c = 0; c < 80; c++) begin
            exp_t e;
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) begin
                p = 4'($urandom_range(0, 15));
                if (legal_index(p) < 0) begin
                    force_pattern(p);
                    check_out("inject", p, 3'd0, 8'b0000_0000, 1'b1);
                    mi   = 0;
                    e.q  = JOHNSON_SEQ[0];
                    e.idx = 0;
                    sb.push_back(e);
                    continue;
                end
            end
            en = ($urandom_range(0, 3) != 0);
            if (en) mi = (mi + 1) % JOHNSON_STATES;
            e.q   = JOHNSON_SEQ[mi];
            e.idx = mi;
            sb.push_back(e);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drain", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/johnson_4.md
Name: johnson_4

Overview:
- 4-stage synchronous Johnson (twisted-ring) counter built from four D flip-flop stages, d0..d3.
- Stage 3's complement feeds stage 0, giving a fixed 8-state cycle.
- Provides true and complemented state, a binary state index and a one-hot state decode for downstream sequencing and timing logic.
- Detects illegal (non-Johnson) patterns and self-corrects.

Parameters:
- WIDTH, 4, number of ring stages. Only 4 is supported; index and decode widths below are sized for 4 stages, giving 8 states.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; when 0, state holds.
- q  output  4  counter state; q[0] = stage d0 ... q[3] = stage d3.
- qbar  output  4  bitwise complement of q, always ~q.
- state_idx  output  3  binary index of the current legal state, 0..7.
- state_dec  output  8  one-hot decode; bit state_idx set.
- illegal  output  1  high while q holds a non-Johnson pattern.

Behaviour:
- Reset (asynchronous, rst=1):
  - q=0000 immediately, independent of clk.
  - qbar=1111, state_idx=0, state_dec=00000001, illegal=0.
  - Reset mid-count returns to 0000 at once; counting resumes on the first rising edge after rst deasserts.
- Next state on rising clk edge when en=1 and the state is legal:
  - q[0] <= ~q[3]
  - q[1] <= q[0]
  - q[2] <= q[1]
  - q[3] <= q[2]
- Legal sequence, index 0..7: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000.
  - Wrap-around: 1000 -> 0000.
  - Period is 8 clocks.
- Hold: en=0 keeps q unchanged, and every output stays stable.
- Illegal states: the 8 patterns outside the legal set (e.g. 0101, 1010, 0010, 0100, 0110, 1001, 1011, 1101).
  - illegal=1 combinationally.
  - state_idx=0 and state_dec=00000000 while illegal.
  - On the next rising edge the counter loads 0000, regardless of en (self-correction).
  - Recovery therefore takes at most 1 clock.
- Output timing:
  - qbar, state_idx, state_dec and illegal are purely combinational from q.
  - No extra latency.
  - Glitch-free with respect to the clock edge only.
- Stage flops: each stage is a D flip-flop with async active-high reset to 0.
  - Stages are instantiated as d0..d3, and each exposes its stored bit as an internal signal named q.
  - Benches may force these stage signals hierarchically, e.g. uut.d2.q, to preload patterns; the design must tolerate arbitrary 4-bit preloads.
- No power-on value is guaranteed without reset. Until reset or preload, outputs may be X.

Decomposition:
- Shared package holds:
  - JOHNSON_STAGES=4
  - JOHNSON_STATES=8
  - a localparam array of the 8 legal patterns in index order, used by both RTL decode and bench scoreboard.
- One sub-module, johnson_dff: inputs clk, rst, d; output q. Single async-reset D flip-flop, instantiated four times as d0..d3.
- Next-state mux, legality check and decode stay in johnson_4.

Test Plan:
- Reset then count: rst=1 for 12 ns, release, en=1, 10 ns clock, run 200 ns.
  - q sequence: 0000,0001,0011,0111,1111,1110,1100,1000,0000...
  - qbar=~q every cycle.
  - state_idx 0..7 repeating.
- Enable hold: during count at q=0111, drop en for 3 clocks.
  - q stays 0111, state_dec=00001000.
  - On re-enable the next value is 1111.
- Async reset mid-operation: assert rst between edges while q=1110.
  - q=0000 before the next edge, state_idx=0, illegal=0.
- Illegal recovery: force d0..d3 to pattern 0101, then release.
  - illegal=1 and state_dec=00000000.
  - After one rising edge, q=0000 even with en=0.
- Stage preload: force all stage q to 0 with no reset, as a bench would.
  - Counter starts 0000 and follows the legal sequence.
  - Wrap 1000 -> 0000 occurs on the 8th edge.
